// File: rtl/ventilador_pwm_if.sv
// Fan power-stage bus: speed commands in, PWM drive and ramp status out.
interface ventilador_pwm_if #(
    parameter int W = 8
);
    logic         s1;
    logic         s2;
    logic         pwm;
    logic [W-1:0] duty;
    logic [1:0]   estado;
    logic         em_regime;

    // Command source / monitor side.
    modport master (
        output s1, s2,
        input  pwm, duty, estado, em_regime
    );

    // Power stage side.
    modport slave (
        input  s1, s2,
        output pwm, duty, estado, em_regime
    );
endinterface

// File: rtl/ventilador_pwm.sv
// Fan PWM power stage: synchronises the speed commands, ramps the duty one
// LSB every RAMP_DIV clocks towards the commanded level and drives a
// registered PWM whose period is 2^W-1 clocks.
module ventilador_pwm #(
    parameter int W          = 8,
    parameter int DUTY_BAIXA = 128,
    parameter int DUTY_ALTA  = 255,
    parameter int RAMP_DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    ventilador_pwm_if.slave  bus
);
    localparam int DW = $clog2(RAMP_DIV);

    // Counter tops out at 2^W-2 so that duty=2^W-1 yields a constant high.
    localparam logic [W-1:0]  CNT_MAX  = {{(W-1){1'b1}}, 1'b0};
    localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);
    localparam logic [W-1:0]  T_BAIXA  = W'(DUTY_BAIXA);
    localparam logic [W-1:0]  T_ALTA   = W'(DUTY_ALTA);

    typedef enum logic [1:0] {
        PARADO        = 2'd0,
        ACELERANDO    = 2'd1,
        REGIME        = 2'd2,
        DESACELERANDO = 2'd3
    } estado_t;

    logic          s1_q1, s1_q2, s2_q1, s2_q2;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [W-1:0]  duty_q, duty_d;
    logic          pwm_q, pwm_d;
    estado_t       estado_q, estado_d;
    logic          em_regime_q, em_regime_d;

    logic [W-1:0]  target;
    logic          ramping;
    logic          step;

    // Two-flop synchronisers for the asynchronous speed commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q1 <= 1'b0;
            s1_q2 <= 1'b0;
            s2_q1 <= 1'b0;
            s2_q2 <= 1'b0;
        end else begin
            s1_q1 <= bus.s1;
            s1_q2 <= s1_q1;
            s2_q1 <= bus.s2;
            s2_q2 <= s2_q1;
        end
    end

    // Target selection, PWM counter, ramp divider and duty stepping.
    always_comb begin
        if (s2_q2)      target = T_ALTA;
        else if (s1_q2) target = T_BAIXA;
        else            target = '0;

        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + W'(1);
        pwm_d = (cnt_q < duty_q);

        ramping = (estado_q == ACELERANDO) || (estado_q == DESACELERANDO);
        if (!ramping)               div_d = '0;
        else if (div_q == DIV_LAST) div_d = '0;
        else                        div_d = div_q + DW'(1);

        // Direction comes from the registered state; the target bound keeps
        // the duty from overshooting when the command changes mid-ramp.
        step   = ramping && (div_q == DIV_LAST);
        duty_d = duty_q;
        if (step && (estado_q == ACELERANDO) && (duty_q < target))
            duty_d = duty_q + W'(1);
        else if (step && (estado_q == DESACELERANDO) && (duty_q > target))
            duty_d = duty_q - W'(1);
    end

    // Ramp state transitions, judged on the registered duty against the target.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            PARADO: begin
                if (target != '0) estado_d = ACELERANDO;
            end
            ACELERANDO: begin
                if (duty_q == target)     estado_d = REGIME;
                else if (target < duty_q) estado_d = DESACELERANDO;
            end
            REGIME: begin
                if (target > duty_q)      estado_d = ACELERANDO;
                else if (target < duty_q) estado_d = DESACELERANDO;
            end
            DESACELERANDO: begin
                if (duty_q == target)     estado_d = (target == '0) ? PARADO : REGIME;
                else if (target > duty_q) estado_d = ACELERANDO;
            end
            default: estado_d = PARADO;
        endcase
        em_regime_d = (estado_d == REGIME);
    end

    // Datapath and state registers; reset drops the duty straight to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            div_q       <= '0;
            duty_q      <= '0;
            pwm_q       <= 1'b0;
            estado_q    <= PARADO;
            em_regime_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            duty_q      <= duty_d;
            pwm_q       <= pwm_d;
            estado_q    <= estado_d;
            em_regime_q <= em_regime_d;
        end
    end

    assign bus.pwm       = pwm_q;
    assign bus.duty      = duty_q;
    assign bus.estado    = estado_q;
    assign bus.em_regime = em_regime_q;
endmodule

// File: tb/tb_ventilador_pwm.sv
// Directed bench for ventilador_pwm with W=4, DUTY_BAIXA=8, DUTY_ALTA=15,
// RAMP_DIV=2. Each vector applies s1/s2, advances n edges and checks the
// duty/estado/em_regime reached.
module tb_ventilador_pwm;
    localparam int W = 4;

    typedef struct {
        logic s1;
        logic s2;
        int   n;
        int   duty;
        int   est;
        int   emr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    vec_t tv[$];

    ventilador_pwm_if #(.W(W)) bus ();

    ventilador_pwm #(
        .W(W), .DUTY_BAIXA(8), .DUTY_ALTA(15), .RAMP_DIV(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic s1, input logic s2, input int n,
                       input int d, input int e, input int r);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.n = n; v.duty = d; v.est = e; v.emr = r;
        tv.push_back(v);
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.s1 = tv[i].s1;
            bus.s2 = tv[i].s2;
            tick(tv[i].n);
            chk($sformatf("vec%0d duty", i), int'(bus.duty), tv[i].duty);
            chk($sformatf("vec%0d estado", i), int'(bus.estado), tv[i].est);
            chk($sformatf("vec%0d em_regime", i), int'(bus.em_regime), tv[i].emr);
        end
    endtask

    task automatic idle_zero(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            chk(name, int'({bus.pwm, bus.duty, bus.estado, bus.em_regime}), 0);
        end
    endtask

    initial begin
        int hi_cnt;

        // Edge counts below start from the last edge before the new command
        // is sampled: target visible after edge 2, ramp state at edge 3,
        // duty=n at edge 3+2n.
        // Ramp up to low speed (0..7)
        add(1,0, 2, 0,0,0); add(1,0, 1, 0,1,0); add(1,0, 1, 0,1,0);
        add(1,0, 1, 1,1,0); add(1,0, 4, 3,1,0); add(1,0,10, 8,1,0);
        add(1,0, 1, 8,2,1); add(1,0, 5, 8,2,1);
        // High speed wins over low (8..12)
        add(1,1, 2, 8,2,1); add(1,1, 1, 8,1,0); add(1,1, 2, 9,1,0);
        add(1,1,12,15,1,0); add(1,1, 1,15,2,1);
        // Back down to low speed (13..17)
        add(1,0, 2,15,2,1); add(1,0, 1,15,3,0); add(1,0, 2,14,3,0);
        add(1,0,12, 8,3,0); add(1,0, 1, 8,2,1);
        // Down to stop (18..22)
        add(0,0, 2, 8,2,1); add(0,0, 1, 8,3,0); add(0,0, 2, 7,3,0);
        add(0,0,14, 0,3,0); add(0,0, 1, 0,0,0);
        // Ramp up, command withdrawn just before duty reaches 5 (23..28)
        add(1,0,12, 4,1,0); add(0,0, 1, 5,1,0); add(0,0, 2, 5,3,0);
        add(0,0, 2, 4,3,0); add(0,0, 8, 0,3,0); add(0,0, 1, 0,0,0);
        // Ramp up to duty 5 for the reset test (29)
        add(1,0,13, 5,1,0);

        bus.s1 = 1'b0;
        bus.s2 = 1'b0;
        rst_n  = 1'b0;
        #2;
        chk("reset outputs", int'({bus.pwm, bus.duty, bus.estado, bus.em_regime}), 0);
        tick(2);
        rst_n = 1'b1;
        idle_zero("idle after reset", 50);

        run_vec(0, 7);

        // Duty 8 over a full 15-clock period
        hi_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            hi_cnt += int'(bus.pwm);
        end
        chk("pwm high count duty8", hi_cnt, 8);

        run_vec(8, 12);

        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            hi_cnt += int'(bus.pwm);
        end
        chk("pwm high count duty15", hi_cnt, 30);

        run_vec(13, 17);

        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("duty holds low level", int'(bus.duty), 8);
        end

        run_vec(18, 22);

        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            hi_cnt += int'(bus.pwm);
        end
        chk("pwm high count duty0", hi_cnt, 0);

        run_vec(23, 28);
        run_vec(29, 29);

        // Asynchronous reset mid-ramp, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset duty", int'(bus.duty), 0);
        chk("async reset estado", int'(bus.estado), 0);
        chk("async reset pwm/em_regime", int'({bus.pwm, bus.em_regime}), 0);
        bus.s1 = 1'b0;
        tick(2);
        rst_n = 1'b1;
        idle_zero("idle after mid-ramp reset", 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ventilador_pwm.md
Name: ventilador_pwm

Overview:
- Downstream power stage of the fan speed decoder.
- Consumes the decoder's two command bits: s1 = low speed, s2 = high speed, s2 dominant.
- Drives the fan motor with a PWM signal. Duty ramps softly towards the commanded level instead of jumping, to limit inrush and noise.
- Reports the current duty and the ramp state for monitoring.

Parameters:
W, 8, duty/PWM counter width; PWM period = 2^W-1 clocks
DUTY_BAIXA, 128, target duty for low speed (s1=1, s2=0)
DUTY_ALTA, 255, target duty for high speed (s2=1); must be <= 2^W-1 and >= DUTY_BAIXA
RAMP_DIV, 4, clocks per 1-LSB duty step while ramping; >= 2

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
s1  input  1  low-speed command from the decoder, asynchronous to clk
s2  input  1  high-speed command from the decoder, asynchronous to clk
pwm  output  1  motor drive, registered
duty  output  W  current applied duty
estado  output  2  0=PARADO, 1=ACELERANDO, 2=REGIME, 3=DESACELERANDO
em_regime  output  1  high when estado==REGIME

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pwm=0, duty=0, estado=PARADO, em_regime=0.
  - Sync flops, PWM counter and ramp divider cleared.
  - Reset mid-ramp drops duty to 0 immediately; there is no ramp-down.
- Input sync: s1 and s2 each pass through a 2-flop synchronizer (s*_q1, s*_q2).
- Target (combinational from q2):
  - s2_q2=1 -> DUTY_ALTA
  - else s1_q2=1 -> DUTY_BAIXA
  - else 0
- PWM counter cnt:
  - Free-running 0..2^W-2, wraps to 0.
  - pwm <= (cnt < duty) every clock.
  - duty=0 gives constant 0; duty=2^W-1 gives constant 1.
- Ramp divider div:
  - Held at 0 while estado is PARADO or REGIME.
  - Otherwise counts 0..RAMP_DIV-1 and wraps.
  - A step occurs on the edge where div==RAMP_DIV-1: duty+1 in ACELERANDO, duty-1 in DESACELERANDO.
  - duty never passes the target. A step is suppressed if duty already equals the target.
- FSM, evaluated each edge on the current registered duty vs target:
  - PARADO: target>0 -> ACELERANDO.
  - ACELERANDO: duty==target -> REGIME; target<duty -> DESACELERANDO.
  - REGIME: target>duty -> ACELERANDO; target<duty -> DESACELERANDO.
  - DESACELERANDO: duty==target -> PARADO if target==0, else REGIME; target>duty -> ACELERANDO.
- Direction reversal mid-ramp: the state switches on the next edge. duty continues from its current value with no jump. div is not cleared on reversal.
- em_regime is registered alongside estado.
- Simultaneous s1/s2 changes: the target follows the priority rule. A glitch shorter than the synchronizer latency may still be seen for one cycle; that is acceptable.
- Timing, RAMP_DIV=2, from PARADO, s1 rising before edge 0:
  - Target visible after edge 2.
  - estado=ACELERANDO at edge 3.
  - duty=n at edge 3+2n.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-ramp with duty=5.
  - Required: pwm=0, duty=0, estado=0, em_regime=0 immediately, without waiting for a clock edge.
  - After release with s1=s2=0, all outputs remain 0 for 50 cycles.
- Ramp up, low speed:
  - Setup: W=4, DUTY_BAIXA=8, DUTY_ALTA=15, RAMP_DIV=2; s1=1 set before edge 0.
  - Required: estado=1 at edge 3; duty increments every 2 cycles; duty=8 at edge 19; estado=2 and em_regime=1 at edge 20.
- PWM shape:
  - Stimulus: same parameters, in REGIME with duty=8.
  - Required: pwm high exactly 8 of every 15 clocks.
  - At duty=15 pwm stays constant 1; at duty=0 pwm stays constant 0.
- High-speed priority:
  - Stimulus: from REGIME at duty=8, set s1=1 and s2=1.
  - Required: estado=1; duty ramps 8->15 in 14 cycles, then estado=2.
- Reversal mid-ramp:
  - Stimulus: during ramp-up at duty=5, clear s1.
  - Required: within 3 cycles estado=3; duty decreases 5->0 with no jump; estado=0 one edge after duty reaches 0.
- Ramp down to low:
  - Stimulus: from duty=15, drop s2 while s1=1.
  - Required: estado=3; duty ramps to 8, then estado=2; duty never goes below 8.
